rad_async_fifo_warb: RTL



---
 rtl/rad_async_fifo_warb_if.sv | 34 +++
 rtl/rad_async_fifo_warb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rad_async_fifo_warb_if.sv
// Write-side bus of the async FIFO arbiter: requester handshake, FIFO write
// port and write-domain pointer/status signals.
// slave  : the arbiter (rad_async_fifo_warb)
// master : the environment (requesters plus write-pointer logic)
interface rad_async_fifo_warb_if #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int ADDRSIZE = 3
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   wfull;
  logic [ADDRSIZE:0]      wptr_gray;
  logic [ADDRSIZE:0]      wq2_rptr;
  logic                   winc;
  logic [DWIDTH-1:0]      wdata;
  logic [GW-1:0]          gnt_id;
  logic                   gnt_active;
  logic [ADDRSIZE:0]      wlevel;

  modport slave (
    input  req_valid, req_data, req_last, wfull, wptr_gray, wq2_rptr,
    output req_ready, winc, wdata, gnt_id, gnt_active, wlevel
  );

  modport master (
    output req_valid, req_data, req_last, wfull, wptr_gray, wq2_rptr,
    input  req_ready, winc, wdata, gnt_id, gnt_active, wlevel
  );
endinterface

// File: rtl/rad_async_fifo_warb.sv
// Write-side arbiter/sequencer for the dual-clock Gray-pointer async FIFO.
// Round-robin grants among NREQ requesters, bounded bursts of MAXBURST beats,
// one IDLE bubble per grant. Reports registered write-side occupancy.
// Optional build macro RAD_ASYNC_FIFO_WARB_PKT_EN: packet-atomic mode, where a
// grant is released only on a beat carrying req_last of the grantee.
// Entirely in the wclk domain; wrst is asynchronous, active-high.
module rad_async_fifo_warb #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int ADDRSIZE = 3,
  parameter int MAXBURST = 4
) (
  input  logic                   wclk,
  input  logic                   wrst,
  rad_async_fifo_warb_if.slave   bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST + 1);
  localparam int PW = ADDRSIZE + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef RAD_ASYNC_FIFO_WARB_PKT_EN
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXBURST);
`else
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_gnt_id;
  logic [GW-1:0]   w_gnt_id_nxt;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   w_rr_ptr_nxt;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_nxt;
  logic [PW-1:0]   r_wlevel;

  logic [GW-1:0]   w_pick;
  logic            w_any_valid;
  logic            w_sel_valid;
  logic            w_beat;
`ifdef RAD_ASYNC_FIFO_WARB_PKT_EN
  logic            w_sel_last;
`endif

  logic [NREQ-1:0] w_req_ready;
  logic            w_winc;
  logic [DWIDTH-1:0] w_wdata;
  logic            w_gnt_active;

  // (idx + 1) mod NREQ without a divider
  function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] idx);
    logic [GW-1:0] res;
    if (32'(idx) >= (NREQ - 1)) begin
      res = {GW{1'b0}};
    end else begin
      res = idx + GW'(1);
    end
    return res;
  endfunction

  // First valid requester searching upward from start, wrapping modulo NREQ
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [GW-1:0]   start);
    logic [GW-1:0] idx;
    logic [GW-1:0] res;
    logic          found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
      idx = inc_mod(idx);
    end
    return res;
  endfunction

  // Gray code to binary
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_any_valid = |bus.req_valid;
  assign w_sel_valid = bus.req_valid[r_gnt_id];
  assign w_pick      = rr_pick(bus.req_valid, r_rr_ptr);
  assign w_beat      = (r_state == ST_BURST) && w_sel_valid && !bus.wfull;
`ifdef RAD_ASYNC_FIFO_WARB_PKT_EN
  assign w_sel_last  = bus.req_last[r_gnt_id];
`endif

  // State, grant, round-robin pointer and beat counter registers
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= {GW{1'b0}};
      r_rr_ptr   <= {GW{1'b0}};
      r_beat_cnt <= CNT_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state: grant in IDLE, count beats and decide release in BURST
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid && !bus.wfull) begin
          w_state_nxt    = ST_BURST;
          w_gnt_id_nxt   = w_pick;
          w_beat_cnt_nxt = CNT_ZERO;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_BURST: begin
`ifdef RAD_ASYNC_FIFO_WARB_PKT_EN
        // Only the end of the packet releases; the counter just saturates
        if (w_beat && w_sel_last) begin
          w_state_nxt    = ST_IDLE;
          w_rr_ptr_nxt   = inc_mod(r_gnt_id);
          w_beat_cnt_nxt = CNT_ZERO;
        end else if (w_beat && (r_beat_cnt != CNT_MAX)) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
        end else begin
          w_state_nxt    = ST_BURST;
        end
`else
        // A valid drop wins even under wfull; a full stall merely holds.
        // Both conditions on one beat still produce a single release.
        if (!w_sel_valid) begin
          w_state_nxt    = ST_IDLE;
          w_rr_ptr_nxt   = inc_mod(r_gnt_id);
          w_beat_cnt_nxt = CNT_ZERO;
        end else if (w_beat && (r_beat_cnt == CNT_LAST)) begin
          w_state_nxt    = ST_IDLE;
          w_rr_ptr_nxt   = inc_mod(r_gnt_id);
          w_beat_cnt_nxt = CNT_ZERO;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
        end else begin
          w_state_nxt    = ST_BURST;
        end
`endif
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_gnt_id_nxt   = {GW{1'b0}};
        w_rr_ptr_nxt   = {GW{1'b0}};
        w_beat_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from state so reset kills a beat immediately
  always_comb begin
    w_req_ready  = {NREQ{1'b0}};
    w_winc       = 1'b0;
    w_gnt_active = 1'b0;
    w_wdata      = {DWIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt_id == GW'(i)) begin
        w_wdata = bus.req_data[i*DWIDTH +: DWIDTH];
      end else begin
        w_wdata = w_wdata;
      end
    end
    case (r_state)
      ST_IDLE: begin
        w_gnt_active = 1'b0;
      end
      ST_BURST: begin
        w_gnt_active          = 1'b1;
        w_req_ready[r_gnt_id] = !bus.wfull;
        w_winc                = w_beat;
      end
      default: begin
        w_gnt_active = 1'b0;
      end
    endcase
  end

  // Write-side occupancy; pessimistic because the read pointer is synchronized
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wlevel <= {PW{1'b0}};
    end else begin
      r_wlevel <= gray2bin(bus.wptr_gray) - gray2bin(bus.wq2_rptr);
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.winc       = w_winc;
  assign bus.wdata      = w_wdata;
  assign bus.gnt_id     = r_gnt_id;
  assign bus.gnt_active = w_gnt_active;
  assign bus.wlevel     = r_wlevel;

endmodule
